// File: rtl/head_flit_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : head_flit_decoder_pkg
// Purpose : Port codes and default-route helper for the head flit decoder.
// Rev     : 1.0
// ============================================================================
package head_flit_decoder_pkg;

  typedef enum logic [1:0] {
    PORT_LOCAL = 2'd0,
    PORT_EAST  = 2'd1,
    PORT_WEST  = 2'd2
  } port_code_e;

  // Dimension-order default: eject at home, otherwise head toward the target ID.
  function automatic port_code_e default_entry(input int entry, input int index);
    if (entry == index)     return PORT_LOCAL;
    else if (entry > index) return PORT_EAST;
    else                    return PORT_WEST;
  endfunction

endpackage
`default_nettype wire

// File: rtl/head_flit_decoder_if.sv
`default_nettype none
// ============================================================================
// Module  : head_flit_decoder_if
// Purpose : Head flit lookup and routing-table configuration bundle.
// Rev     : 1.0
// ============================================================================
interface head_flit_decoder_if #(
  parameter int FLIT_W        = 16,
  parameter int DEST_W        = 2,
  parameter int REQUEST_WIDTH = 2
);
  logic [FLIT_W-1:0]        HeadFlit;
  logic [REQUEST_WIDTH-1:0] RequestMessage;
  logic                     routeError;
  logic                     cfgWrite;
  logic [DEST_W-1:0]        cfgDest;
  logic [REQUEST_WIDTH-1:0] cfgPort;

  modport master (
    output HeadFlit, cfgWrite, cfgDest, cfgPort,
    input  RequestMessage, routeError
  );

  modport slave (
    input  HeadFlit, cfgWrite, cfgDest, cfgPort,
    output RequestMessage, routeError
  );
endinterface
`default_nettype wire

// File: rtl/head_flit_decoder_routing_table.sv
`default_nettype none
// ============================================================================
// Module  : head_flit_decoder_routing_table
// Purpose : N-entry route table, registered write side, combinational read.
// Rev     : 1.0
// ============================================================================
module head_flit_decoder_routing_table
  import head_flit_decoder_pkg::*;
#(
  parameter int N             = 4,
  parameter int INDEX         = 1,
  parameter int DEST_W        = 2,
  parameter int REQUEST_WIDTH = 2
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     wr_en,
  input  wire logic [DEST_W-1:0]        wr_addr,
  input  wire logic [REQUEST_WIDTH-1:0] wr_data,
  input  wire logic [DEST_W-1:0]        rd_addr,
  output logic      [REQUEST_WIDTH-1:0] rd_data
);

  localparam logic [DEST_W:0] N_L = (DEST_W+1)'(N);

  logic [REQUEST_WIDTH-1:0] tbl [N];

  // Addresses at or above N match no entry, so such writes fall away naturally.
  for (genvar e = 0; e < N; e++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst)
        tbl[e] <= REQUEST_WIDTH'(default_entry(e, INDEX));
      else if (wr_en && (wr_addr == DEST_W'(e)))
        tbl[e] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < N_L)
      rd_data = tbl[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/head_flit_decoder.sv
`default_nettype none
// ============================================================================
// Module  : head_flit_decoder
// Purpose : Maps the head flit destination to an output-port request.
// Rev     : 1.0
// ============================================================================
module head_flit_decoder
  import head_flit_decoder_pkg::*;
#(
  parameter int N             = 4,
  parameter int INDEX         = 1,
  parameter int DATA_WIDTH    = 8,
  parameter int PhitPerFlit   = 2,
  parameter int REQUEST_WIDTH = 2
) (
  input wire logic          clk,
  input wire logic          rst,
  head_flit_decoder_if.slave bus
);

  localparam int FLIT_W = DATA_WIDTH * PhitPerFlit;
  localparam int DEST_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [DEST_W:0]        N_L = (DEST_W+1)'(N);
  localparam logic [REQUEST_WIDTH-1:0] ERR = '1;

  logic [DEST_W-1:0]        dest;
  logic                     dest_in_range;
  logic [REQUEST_WIDTH-1:0] table_port;
  logic                     unused_flit_bits;

  assign dest             = bus.HeadFlit[DEST_W-1:0];
  assign unused_flit_bits = ^bus.HeadFlit[FLIT_W-1:DEST_W];
  assign dest_in_range    = ({1'b0, dest} < N_L);

  head_flit_decoder_routing_table #(
    .N             (N),
    .INDEX         (INDEX),
    .DEST_W        (DEST_W),
    .REQUEST_WIDTH (REQUEST_WIDTH)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.cfgWrite),
    .wr_addr (bus.cfgDest),
    .wr_data (bus.cfgPort),
    .rd_addr (dest),
    .rd_data (table_port)
  );

  // Outputs are deliberately not gated by rst: they always show the live table.
  always_comb begin
    bus.RequestMessage = ERR;
    bus.routeError     = 1'b1;
    if (dest_in_range) begin
      bus.RequestMessage = table_port;
      bus.routeError     = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_head_flit_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_head_flit_decoder
// Purpose : Directed vector bench for head_flit_decoder (several parameter sets).
// Rev     : 1.0
// ============================================================================
module tb_head_flit_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // N=4, INDEX=1
  head_flit_decoder_if #(.FLIT_W(16), .DEST_W(2), .REQUEST_WIDTH(2)) a_if ();
  head_flit_decoder #(.N(4), .INDEX(1), .DATA_WIDTH(8), .PhitPerFlit(2), .REQUEST_WIDTH(2))
    dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));

  // N=3, INDEX=0
  head_flit_decoder_if #(.FLIT_W(16), .DEST_W(2), .REQUEST_WIDTH(2)) b_if ();
  head_flit_decoder #(.N(3), .INDEX(0), .DATA_WIDTH(8), .PhitPerFlit(2), .REQUEST_WIDTH(2))
    dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  // N=4, INDEX=0..3 sharing one head flit
  logic [15:0] sw_flit;
  logic [1:0]  sw_req [4];
  logic        sw_err [4];

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    head_flit_decoder_if #(.FLIT_W(16), .DEST_W(2), .REQUEST_WIDTH(2)) sif ();
    assign sif.HeadFlit = sw_flit;
    assign sif.cfgWrite = 1'b0;
    assign sif.cfgDest  = 2'd0;
    assign sif.cfgPort  = 2'd0;
    head_flit_decoder #(.N(4), .INDEX(g), .DATA_WIDTH(8), .PhitPerFlit(2), .REQUEST_WIDTH(2))
      dut (.clk(clk), .rst(rst), .bus(sif.slave));
    assign sw_req[g] = sif.RequestMessage;
    assign sw_err[g] = sif.routeError;
  end

  typedef struct {
    logic [15:0] flit;
    int          req;
    int          err;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_a(input string name, input logic [15:0] flit, input int req, input int err);
    a_if.HeadFlit = flit;
    #1;
    check({name, " req"}, int'(a_if.RequestMessage), req);
    check({name, " err"}, int'(a_if.routeError), err);
  endtask

  task automatic check_b(input string name, input logic [15:0] flit, input int req, input int err);
    b_if.HeadFlit = flit;
    #1;
    check({name, " req"}, int'(b_if.RequestMessage), req);
    check({name, " err"}, int'(b_if.routeError), err);
  endtask

  vec_t va [6];
  vec_t vb [4];

  initial begin
    va[0] = '{16'h0001, 0, 0};
    va[1] = '{16'h0003, 1, 0};
    va[2] = '{16'h0000, 2, 0};
    va[3] = '{16'hAB02, 1, 0};
    va[4] = '{16'hFFFC, 2, 0};
    va[5] = '{16'h0002, 1, 0};

    vb[0] = '{16'h0003, 3, 1};
    vb[1] = '{16'h0002, 1, 0};
    vb[2] = '{16'h0001, 1, 0};
    vb[3] = '{16'h0000, 0, 0};

    a_if.HeadFlit = 16'h0003; a_if.cfgWrite = 1'b0; a_if.cfgDest = 2'd0; a_if.cfgPort = 2'd0;
    b_if.HeadFlit = 16'h0000; b_if.cfgWrite = 1'b0; b_if.cfgDest = 2'd0; b_if.cfgPort = 2'd0;
    sw_flit = 16'h0000;

    // Outputs follow the table while rst is still held
    @(posedge clk); #1;
    check_a("in_reset dest3", 16'h0003, 1, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      check_a($sformatf("a_vec%0d", i), va[i].flit, va[i].req, va[i].err);

    // Write entry 3 -> 2: old value in the write cycle, new value afterwards
    @(posedge clk); #1;
    a_if.HeadFlit = 16'h0003;
    a_if.cfgWrite = 1'b1; a_if.cfgDest = 2'd3; a_if.cfgPort = 2'd2;
    #1;
    check("cfg write-cycle old", int'(a_if.RequestMessage), 1);
    @(posedge clk); #1;
    a_if.cfgWrite = 1'b0;
    check_a("cfg new dest3", 16'h0003, 2, 0);
    check_a("cfg other dest0", 16'h0000, 2, 0);
    check_a("cfg other dest1", 16'h0001, 0, 0);
    check_a("cfg other dest2", 16'h0002, 1, 0);

    // Mid-operation reset drops the configured route
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_a("reset restores dest3", 16'h0003, 1, 0);

    // rst dominates a simultaneous write
    rst = 1'b1;
    a_if.cfgWrite = 1'b1; a_if.cfgDest = 2'd3; a_if.cfgPort = 2'd2;
    @(posedge clk); #1;
    rst = 1'b0;
    a_if.cfgWrite = 1'b0;
    check_a("rst wins dest3", 16'h0003, 1, 0);
    @(posedge clk); #1;
    check_a("rst wins dest3 later", 16'h0003, 1, 0);

    // N=3: out-of-range destination
    for (int i = 0; i < 4; i++)
      check_b($sformatf("b_vec%0d", i), vb[i].flit, vb[i].req, vb[i].err);

    // Out-of-range write must not disturb any entry
    @(posedge clk); #1;
    b_if.cfgWrite = 1'b1; b_if.cfgDest = 2'd3; b_if.cfgPort = 2'd0;
    @(posedge clk); #1;
    b_if.cfgWrite = 1'b0;
    for (int i = 0; i < 4; i++)
      check_b($sformatf("b_after_oor_wr%0d", i), vb[i].flit, vb[i].req, vb[i].err);

    // Default-rule sweep across every INDEX
    for (int d = 0; d < 4; d++) begin
      sw_flit = 16'(d);
      #1;
      for (int idx = 0; idx < 4; idx++) begin
        int exp_req;
        exp_req = (d == idx) ? 0 : ((d > idx) ? 1 : 2);
        check($sformatf("sweep idx%0d dest%0d req", idx, d), int'(sw_req[idx]), exp_req);
        check($sformatf("sweep idx%0d dest%0d err", idx, d), int'(sw_err[idx]), 0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
